// File: rtl/sevseg_reader.sv
// sevseg_reader: decodes a two-digit multiplexed active-low 7-segment bus back to hex nibbles.
// Latency: a value steady at the pins commits (upd pulse) STABLE_CYCLES+1 edges after it first appears.
// Backpressure: none; free-running sampler. Optional decimal point via `define SEVSEG_READER_DP_EN.
module sevseg_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg_n,
   input  logic [1:0] an_n,
`ifdef SEVSEG_READER_DP_EN
   input  logic       dp_n,
   output logic       dp_lo,
   output logic       dp_hi,
`endif
   output logic [3:0] digit_lo,
   output logic [3:0] digit_hi,
   output logic       blank_lo,
   output logic       blank_hi,
   output logic       upd,
   output logic       bad,
   output logic       bad_sticky
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] TRACK = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

`ifdef SEVSEG_READER_DP_EN
   localparam int SW = 10;
   localparam logic [SW-1:0] SAMP_RST = {1'b1, 2'b11, 7'h7F};
   logic [SW-1:0] din;
   assign din = {dp_n, an_n, seg_n};
`else
   localparam int SW = 9;
   localparam logic [SW-1:0] SAMP_RST = {2'b11, 7'h7F};
   logic [SW-1:0] din;
   assign din = {an_n, seg_n};
`endif

   logic [SW-1:0] samp;
   logic [CW-1:0] cnt;
   logic [1:0]    state;

   // Glyph lookup on active-high gfedcba; returns {legal, nibble}.
   function automatic logic [4:0] decode(input logic [6:0] lit);
      case (lit)
         7'h3F: decode = {1'b1, 4'h0};
         7'h06: decode = {1'b1, 4'h1};
         7'h5B: decode = {1'b1, 4'h2};
         7'h4F: decode = {1'b1, 4'h3};
         7'h66: decode = {1'b1, 4'h4};
         7'h6D: decode = {1'b1, 4'h5};
         7'h7D: decode = {1'b1, 4'h6};
         7'h07: decode = {1'b1, 4'h7};
         7'h7F: decode = {1'b1, 4'h8};
         7'h6F: decode = {1'b1, 4'h9};
         7'h77: decode = {1'b1, 4'hA};
         7'h7C: decode = {1'b1, 4'hB};
         7'h39: decode = {1'b1, 4'hC};
         7'h5E: decode = {1'b1, 4'hD};
         7'h79: decode = {1'b1, 4'hE};
         7'h71: decode = {1'b1, 4'hF};
         default: decode = {1'b0, 4'h0};
      endcase
   endfunction

   logic       din_an_ok;
   logic       samp_lo;
   logic [6:0] samp_seg;
   logic       samp_blank;
   logic [4:0] samp_dec;

   // Exactly one anode low selects a digit; 2'b00/2'b11 mean nothing to track.
   assign din_an_ok  = din[8] ^ din[7];
   assign samp_lo    = (samp[8:7] == 2'b10);
   assign samp_seg   = samp[6:0];
   assign samp_blank = (samp_seg == 7'h7F);
   assign samp_dec   = decode(~samp_seg);

   // Sampler, stability counter, tracking FSM and committed digit registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         samp       <= SAMP_RST;
         cnt        <= '0;
         state      <= IDLE;
         digit_lo   <= 4'h0;
         digit_hi   <= 4'h0;
         blank_lo   <= 1'b1;
         blank_hi   <= 1'b1;
         upd        <= 1'b0;
         bad        <= 1'b0;
         bad_sticky <= 1'b0;
`ifdef SEVSEG_READER_DP_EN
         dp_lo      <= 1'b0;
         dp_hi      <= 1'b0;
`endif
      end else begin
         upd  <= 1'b0;
         bad  <= 1'b0;
         samp <= din;
         if (din != samp) begin
            // Any change (segments, anode or dp) restarts the stability window.
            cnt   <= din_an_ok ? CW'(1) : '0;
            state <= din_an_ok ? TRACK : IDLE;
         end else begin
            case (state)
               TRACK: begin
                  if (cnt == CNT_MAX) begin
                     state <= HOLD;
                     upd   <= 1'b1;
                     if (samp_blank) begin
                        if (samp_lo) blank_lo <= 1'b1;
                        else         blank_hi <= 1'b1;
                     end else if (samp_dec[4]) begin
                        if (samp_lo) begin
                           digit_lo <= samp_dec[3:0];
                           blank_lo <= 1'b0;
                        end else begin
                           digit_hi <= samp_dec[3:0];
                           blank_hi <= 1'b0;
                        end
                     end else begin
                        bad        <= 1'b1;
                        bad_sticky <= 1'b1;
                     end
`ifdef SEVSEG_READER_DP_EN
                     if (samp_lo) dp_lo <= ~samp[9];
                     else         dp_hi <= ~samp[9];
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               HOLD:    cnt <= cnt;
               default: cnt <= '0;
            endcase
         end
      end
   end

endmodule
